// File: rtl/filter_sample_source.sv
// Test-stimulus generator for the FIR datapath: zero/impulse/step/ramp/square/noise samples
// emitted at a programmable rate over a valid/ready handshake.
module filter_sample_source #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [7:0]           rate_div,
  input  logic [WIDTH-1:0]     amplitude,
  input  logic [7:0]           period,
  output logic [WIDTH-1:0]     sample_out,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sample_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q;
  logic [2:0]       mode_q;
  logic [7:0]       div_q;
  logic             first_q;      // sample index is still 0
  logic [7:0]       phase_cnt_q;
  logic             phase_low_q;
  logic [WIDTH-1:0] ramp_q;
  logic [7:0]       lfsr_q;

  logic             transfer;
  logic             tick;
  logic             lfsr_fb;
  logic [7:0]       period_eff;
  logic [WIDTH-1:0] gen_sample;

  assign transfer   = sample_valid & sample_ready;
  // >= guards against rate_div shrinking below the running divider
  assign tick       = (state_q == StRun) && enable && (div_q >= rate_div);
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign period_eff = (period == 8'd0) ? 8'd1 : period;
  assign busy       = (state_q != StIdle);

  always_comb begin
    gen_sample = '0;
    case (mode_q)
      3'd1:    gen_sample = first_q ? amplitude : '0;
      3'd2:    gen_sample = amplitude;
      3'd3:    gen_sample = ramp_q;
      3'd4:    gen_sample = phase_low_q ? '0 : amplitude;
      3'd5:    gen_sample = WIDTH'(lfsr_q) & amplitude;
      default: gen_sample = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= 3'd0;
      div_q        <= 8'd0;
      first_q      <= 1'b1;
      phase_cnt_q  <= 8'd0;
      phase_low_q  <= 1'b0;
      ramp_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
    end else begin
      if (transfer) begin
        sample_valid <= 1'b0;
        if (sample_count != '1) sample_count <= sample_count + CNT_WIDTH'(1);
      end
      case (state_q)
        StIdle: begin
          if (enable) begin
            mode_q      <= mode;
            div_q       <= 8'd0;
            first_q     <= 1'b1;
            phase_cnt_q <= 8'd0;
            phase_low_q <= 1'b0;
            ramp_q      <= '0;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (!enable) begin
            state_q <= (sample_valid && !sample_ready) ? StDrain : StIdle;
          end else begin
            div_q <= tick ? 8'd0 : div_q + 8'd1;
            if (tick) begin
              if (!sample_valid || sample_ready) begin
                // a load here overrides the valid clear from a same-cycle transfer
                sample_out   <= gen_sample;
                sample_valid <= 1'b1;
                first_q      <= 1'b0;
                if (mode_q == 3'd3) ramp_q <= ramp_q + amplitude;
                if (mode_q == 3'd4) begin
                  if (phase_cnt_q + 8'd1 >= period_eff) begin
                    phase_cnt_q <= 8'd0;
                    phase_low_q <= ~phase_low_q;
                  end else begin
                    phase_cnt_q <= phase_cnt_q + 8'd1;
                  end
                end
                if (mode_q == 3'd5) lfsr_q <= {lfsr_q[6:0], lfsr_fb};
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        StDrain: begin
          if (!sample_valid || transfer) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/filter_sample_source.md
Name: filter_sample_source

Overview:
Test-stimulus generator that produces 8-bit samples for the FIR filter datapath input. It supports selectable waveforms: zero, impulse, step, ramp, square and LFSR noise. Samples are emitted at a programmable rate over a valid/ready handshake. The block sits upstream of the filter and drives its sample input for on-chip characterisation, such as impulse and step response.

Parameters:
WIDTH, 8, sample width in bits
CNT_WIDTH, 16, width of accepted-sample counter
LFSR_SEED, 8'hA5, noise LFSR value after reset (must be nonzero)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
enable  input  1  start/continue generation
mode  input  3  waveform select, latched on IDLE->RUN
rate_div  input  8  sample period = rate_div+1 cycles
amplitude  input  WIDTH  waveform amplitude / ramp step / noise mask
period  input  8  square half-period in samples (0 treated as 1)
sample_out  output  WIDTH  sample data
sample_valid  output  1  sample_out holds a sample
sample_ready  input  1  consumer accepts the sample
overrun  output  1  sticky: a tick was dropped due to a pending sample
busy  output  1  state != IDLE
sample_count  output  CNT_WIDTH  accepted transfers, saturating

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - sample_out=0, sample_valid=0, overrun=0, busy=0, sample_count=0.
  - state=IDLE, divider=0, sample index=0, square phase counter=0.
  - lfsr=LFSR_SEED, ramp accumulator=0.
- Reset takes priority over all other inputs. Asserted mid-transfer, it drops sample_valid on the next edge regardless of sample_ready.
- FSM states:
  - IDLE: on enable=1, latch mode, clear divider, index, ramp accumulator and phase counter; next state RUN. overrun and sample_count are not cleared (reset only).
  - RUN: divider counts 0..rate_div. A tick occurs in the cycle where divider==rate_div, and divider returns to 0. If enable=0, go to DRAIN when a sample is pending, else to IDLE; no tick is processed in that cycle.
  - DRAIN: no ticks. Hold the pending sample until the handshake completes, then go to IDLE.
- Handshake:
  - A transfer occurs when sample_valid & sample_ready.
  - sample_out and sample_valid are stable while valid=1 and ready=0.
  - sample_valid rises one cycle after the tick (registered).
  - Tick in the same cycle as a transfer: the new sample loads and valid stays 1.
  - Tick while valid=1 and no transfer: the tick is dropped, overrun is set, and generator state does not advance.
- Throughput: with rate_div=0 and ready held high, one new sample per cycle; the first valid appears 2 cycles after enable is sampled high.
- Waveform for sample index n (n increments only on a generated sample):
  - 0, zero: 0.
  - 1, impulse: amplitude at n=0, else 0.
  - 2, step: amplitude.
  - 3, ramp: accumulator value, then accumulator += amplitude mod 2^WIDTH (wraps).
  - 4, square: amplitude for `period` samples, then 0 for `period` samples, repeating; starts high.
  - 5, noise: lfsr & amplitude, then lfsr shifts left, feedback = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1).
  - 6, 7: treated as zero.
- rate_div, amplitude and period are sampled live at each tick. mode changes during RUN are ignored.
- sample_count increments on each transfer and saturates at all-ones.
- The LFSR is not reseeded on IDLE->RUN; only reset restores the seed.

Test Plan:
- Impulse: reset, mode=1, amplitude=0x40, rate_div=0, ready=1, enable=1 -> samples 0x40,0x00,0x00,0x00; first valid 2 cycles after enable; sample_count=4 after 4 transfers.
- Ramp wrap: mode=3, amplitude=3 -> 0x00,0x03,...,0xFC,0xFF,0x02,0x05; no overrun.
- Square: mode=4, amplitude=0x7F, period=2, rate_div=3 -> 0x7F,0x7F,0x00,0x00,0x7F; new sample every 4 cycles.
- Backpressure: mode=2, amplitude=0x11, rate_div=1, ready low for 6 cycles after first valid -> sample_out holds 0x11, overrun=1, sample_count unchanged until ready returns high.
- Noise and drain: mode=5, amplitude=0xFF, seed 0xA5 -> 0xA5,0x4A,0x95. Then drop enable with ready=0 -> state DRAIN, busy=1, valid held; ready=1 -> one transfer, then IDLE, busy=0, valid=0.
- Reset mid-run: assert reset while valid=1, ready=0 -> next cycle valid=0, count=0, overrun=0; re-enable with mode=5 -> first sample 0xA5.
